// File: rtl/pwm_pkg.sv
// Shared servo-PWM constants and FSM state type, common to the capture
// and generator blocks.
package pwm_pkg;

    localparam int PWM_PERIOD_CYCLES = 1_000_000;
    localparam int PWM_MIN_PULSE     = 25_000;
    localparam int PWM_MAX_PULSE     = 125_000;
    localparam int PWM_CNT_W         = 21;
    localparam int PWM_DIV_W         = 24;
    localparam int POS_MAX           = 100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } pwm_state_e;

endpackage

// File: rtl/pwm_div.sv
// Serial restoring divider: DIV_W quotient bits, one per cycle. The first
// bit is resolved on the start edge, so done follows start by DIV_W cycles.
module pwm_div #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] num,
    input  logic [DIV_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quot
);

    localparam int CW = $clog2(DIV_W + 1);

    logic [DIV_W:0]   rem_q, rem_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] den_q, den_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIV_W:0]   step_rem;
    logic [DIV_W-1:0] step_quo;
    logic [DIV_W-1:0] step_den;
    logic [DIV_W:0]   shifted;
    logic [DIV_W+1:0] diff;
    logic [DIV_W:0]   new_rem;
    logic [DIV_W-1:0] new_quo;

    always_comb begin
        step_rem = busy_q ? rem_q : '0;
        step_quo = busy_q ? quo_q : num;
        step_den = busy_q ? den_q : den;
        shifted  = {step_rem[DIV_W-1:0], step_quo[DIV_W-1]};
        // One extra bit keeps the sign unambiguous for any shifted value.
        diff     = {1'b0, shifted} - {2'b00, step_den};
        if (!diff[DIV_W+1]) begin
            new_rem = diff[DIV_W:0];
            new_quo = {step_quo[DIV_W-2:0], 1'b1};
        end else begin
            new_rem = shifted;
            new_quo = {step_quo[DIV_W-2:0], 1'b0};
        end
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (busy_q) begin
            rem_d = new_rem;
            quo_d = new_quo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start) begin
            rem_d  = new_rem;
            quo_d  = new_quo;
            den_d  = den;
            cnt_d  = CW'(DIV_W - 1);
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quot = quo_q;

endmodule

// File: rtl/pwm_capture.sv
// Servo-pulse decoder: measures high time and rise-to-rise period of pwm_in
// and converts the high time to a clamped 0..100 position.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no pulse being tracked; waiting for a rising edge
// HIGH    | input high; counting high time and period
// LOW     | input low after a pulse; counting period until next rise
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int PERIOD_CYCLES = PWM_PERIOD_CYCLES,
    parameter int MIN_PULSE     = PWM_MIN_PULSE,
    parameter int MAX_PULSE     = PWM_MAX_PULSE,
    parameter int CNT_W         = PWM_CNT_W,
    parameter int DIV_W         = PWM_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [7:0]       pos,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             err_range,
    output logic             lost
);

    localparam logic [CNT_W-1:0] H_TIMEOUT = CNT_W'(2 * MAX_PULSE);
    localparam logic [CNT_W-1:0] P_TIMEOUT = CNT_W'(2 * PERIOD_CYCLES);
    localparam logic [CNT_W-1:0] MIN_W     = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_W     = CNT_W'(MAX_PULSE);
    localparam logic [DIV_W-1:0] DEN       = DIV_W'(MAX_PULSE - MIN_PULSE);

    logic s1_q, s2_q, s3_q;
    logic rise, fall;

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] period_r_q, period_r_d;
    logic             punk_q, punk_d;
    logic [CNT_W-1:0] width_r_q, width_r_d;
    logic [CNT_W-1:0] psnap_q, psnap_d;
    logic             start_q, start_d;
    logic             timeout;

    logic [7:0]       pos_q, pos_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;

    logic             div_rst, div_busy, div_done, conv_busy;
    logic [DIV_W-1:0] x, num, quot;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // Synchronizer resets high so a line already high at reset release is
    // not mistaken for a rise; a fresh low-to-high transition is required.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign conv_busy = start_q | div_busy | div_done;

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        pcnt_d     = pcnt_q;
        period_r_d = period_r_q;
        punk_d     = punk_q;
        width_r_d  = width_r_q;
        psnap_d    = psnap_q;
        start_d    = 1'b0;
        timeout    = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
            pcnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        hcnt_d  = CNT_W'(1);
                        pcnt_d  = CNT_W'(1);
                        punk_d  = 1'b1;
                    end
                end
                ST_HIGH: begin
                    hcnt_d = hcnt_q + 1'b1;
                    pcnt_d = pcnt_q + 1'b1;
                    if (fall) begin
                        state_d = ST_LOW;
                        if (!conv_busy) begin
                            width_r_d = hcnt_q;
                            psnap_d   = punk_q ? '0 : period_r_q;
                            start_d   = 1'b1;
                        end
                    end else if (hcnt_q == H_TIMEOUT) begin
                        timeout = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_LOW: begin
                    pcnt_d = pcnt_q + 1'b1;
                    if (rise) begin
                        state_d    = ST_HIGH;
                        period_r_d = pcnt_q;
                        punk_d     = 1'b0;
                        hcnt_d     = CNT_W'(1);
                        pcnt_d     = CNT_W'(1);
                    end else if (pcnt_q == P_TIMEOUT) begin
                        timeout = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // x*100 as shift-add; an under-range width wraps here and is clamped later.
    assign x       = DIV_W'(width_r_q) - DIV_W'(MIN_PULSE);
    assign num     = (x << 6) + (x << 5) + (x << 2);
    assign div_rst = rst | ~en;

    pwm_div #(.DIV_W(DIV_W)) u_div (
        .clk   (clk),
        .rst   (div_rst),
        .start (start_q),
        .num   (num),
        .den   (DEN),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (quot)
    );

    always_comb begin
        pos_d    = pos_q;
        width_d  = width_q;
        period_d = period_q;
        err_d    = err_q;
        lost_d   = lost_q;
        valid_d  = 1'b0;
        if (div_done && en) begin
            valid_d  = 1'b1;
            width_d  = width_r_q;
            period_d = psnap_q;
            lost_d   = 1'b0;
            if (width_r_q < MIN_W) begin
                pos_d = '0;
                err_d = 1'b1;
            end else if (width_r_q > MAX_W) begin
                pos_d = 8'(POS_MAX);
                err_d = 1'b1;
            end else begin
                pos_d = (quot > DIV_W'(POS_MAX)) ? 8'(POS_MAX) : quot[7:0];
                err_d = 1'b0;
            end
        end
        if (timeout) lost_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            pcnt_q     <= '0;
            period_r_q <= '0;
            punk_q     <= 1'b1;
            width_r_q  <= '0;
            psnap_q    <= '0;
            start_q    <= 1'b0;
            pos_q      <= '0;
            width_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            lost_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            pcnt_q     <= pcnt_d;
            period_r_q <= period_r_d;
            punk_q     <= punk_d;
            width_r_q  <= width_r_d;
            psnap_q    <= psnap_d;
            start_q    <= start_d;
            pos_q      <= pos_d;
            width_q    <= width_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            lost_q     <= lost_d;
        end
    end

    assign pos       = pos_q;
    assign width     = width_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign err_range = err_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture with scaled timing parameters.
module tb_pwm_capture;

    localparam int P  = 1000;
    localparam int MN = 25;
    localparam int MX = 125;
    localparam int CW = 11;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          pwm_in;
    logic [7:0]    pos;
    logic [CW-1:0] width;
    logic [CW-1:0] period;
    logic          valid;
    logic          err_range;
    logic          lost;

    pwm_capture #(
        .PERIOD_CYCLES (P),
        .MIN_PULSE     (MN),
        .MAX_PULSE     (MX),
        .CNT_W         (CW),
        .DIV_W         (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pwm_in    (pwm_in),
        .pos       (pos),
        .width     (width),
        .period    (period),
        .valid     (valid),
        .err_range (err_range),
        .lost      (lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int pos;
        int width;
        int period;
        int err;
        int at;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    exp_t last_e = '{0, 0, 0, 0, 0};

    int checks = 0;
    int errors = 0;
    int prev_rise = 0;
    bit prev_known = 1'b0;
    int cur_period = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int exp_pos(input int w);
        if (w < MN) return 0;
        if (w > MX) return 100;
        return ((w - MN) * 100) / (MX - MN);
    endfunction

    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", int'(valid), 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("pos",       int'(pos),       mon_e.pos);
                chk("width",     int'(width),     mon_e.width);
                chk("period",    int'(period),    mon_e.period);
                chk("err_range", int'(err_range), mon_e.err);
                chk("valid_cyc", cyc,             mon_e.at);
                chk("lost_clr",  int'(lost),      0);
                last_e = mon_e;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rise_now();
        pwm_in = 1'b1;
        cur_period = prev_known ? (cyc - prev_rise) : 0;
        prev_rise  = cyc;
        prev_known = 1'b1;
    endtask

    // Fall drive at cycle f: s2 falls at f+2, valid lands 26 cycles later.
    task automatic fall_push(input int h);
        exp_t e;
        pwm_in   = 1'b0;
        e.pos    = exp_pos(h);
        e.width  = h;
        e.period = cur_period;
        e.err    = (h < MN || h > MX) ? 1 : 0;
        e.at     = cyc + 28;
        sbq.push_back(e);
    endtask

    task automatic pulse(input int h, input int l);
        rise_now();
        tick(h);
        fall_push(h);
        tick(l);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sbq.size() != 0; i++) tick(1);
        chk("sb_drained", sbq.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pos"},    int'(pos),       0);
        chk({tag, "_width"},  int'(width),     0);
        chk({tag, "_period"}, int'(period),    0);
        chk({tag, "_valid"},  int'(valid),     0);
        chk({tag, "_err"},    int'(err_range), 0);
        chk({tag, "_lost"},   int'(lost),      1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        rst    = 1'b1;
        en     = 1'b1;
        pwm_in = 1'b0;
        tick(3);
        check_reset_vals("rst0");
        rst = 1'b0;
        tick(5);

        // nominal mid-range pulses
        for (int i = 0; i < 3; i++) pulse(75, 925);
        drain();
        chk("lost_after_run", int'(lost), 0);

        // range boundaries and out-of-range
        pulse(25, 975);
        pulse(125, 875);
        pulse(20, 980);
        pulse(140, 860);
        drain();

        // signal loss: low timeout counted from the last rise
        rc = cyc;
        rise_now();
        tick(75);
        fall_push(75);
        tick(2002 - 75);
        chk("lost_pre_timeout", int'(lost), 0);
        tick(1);
        chk("lost_at_timeout", int'(lost), 1);
        chk("lost_timing_ref", cyc - rc, 2003);
        prev_known = 1'b0;
        pulse(75, 925);
        drain();

        // reset mid-pulse
        pwm_in = 1'b1;
        tick(10);
        rst = 1'b1;
        tick(1);
        check_reset_vals("rst_mid");
        rst = 1'b0;
        tick(65);
        pwm_in = 1'b0;
        tick(925);
        prev_known = 1'b0;
        pulse(75, 925);
        drain();

        // enable dropped during conversion
        pwm_in = 1'b1;
        tick(60);
        pwm_in = 1'b0;
        tick(10);
        en = 1'b0;
        tick(40);
        chk("en_hold_pos",    int'(pos),       last_e.pos);
        chk("en_hold_width",  int'(width),     last_e.width);
        chk("en_hold_period", int'(period),    last_e.period);
        chk("en_hold_err",    int'(err_range), last_e.err);
        chk("en_hold_lost",   int'(lost),      0);
        en = 1'b1;
        prev_known = 1'b0;
        tick(900);
        pulse(75, 925);
        pulse(30, 970);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Servo-pulse decoder: measures high time and rise-to-rise period of an incoming PWM signal and converts the high time to a 0–100 position value. It is the receive-side counterpart of the servo PWM generator and sits after an external pin or feedback line. It produces one strobed sample per pulse and flags out-of-range pulses and signal loss.

## Interface
- PERIOD_CYCLES, 1_000_000: nominal frame length in clk cycles; loss timeout is 2×PERIOD_CYCLES.
- MIN_PULSE, 25_000: high time mapped to position 0.
- MAX_PULSE, 125_000: high time mapped to position 100.
- CNT_W, 21: width of the width and period counters and outputs; must hold 2×PERIOD_CYCLES.
- DIV_W, 24: numerator width of the divider; must hold (MAX_PULSE−MIN_PULSE)×100.

Ports:
- clk  in  1  single clock; everything is on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable.
- pwm_in  in  1  asynchronous PWM input.
- pos  out  8  position 0..100, clamped.
- width  out  CNT_W  last measured high time in cycles.
- period  out  CNT_W  last rise-to-rise interval; 0 if unknown.
- valid  out  1  one-cycle strobe when pos, width, period and err_range update.
- err_range  out  1  qualified by valid: width < MIN_PULSE or width > MAX_PULSE.
- lost  out  1  level: no valid signal is present.

## Operation
- pwm_in passes through a 2-FF synchronizer (s1, s2) and a delay flop s3. A rise is s2 & ~s3; a fall is ~s2 & s3.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on a rise, go to HIGH, set hcnt=1 and pcnt=1. A rise seen in IDLE has no prior rise, so it sets the period-unknown flag.
  - HIGH: hcnt++ and pcnt++ each cycle. On a fall, latch hcnt into width_r, start conversion, and go to LOW. If hcnt reaches 2×MAX_PULSE, set lost and go to IDLE.
  - LOW: pcnt++ each cycle. On a rise, latch pcnt into period_r (clear the unknown flag), set hcnt=1 and pcnt=1, and go to HIGH. If pcnt reaches 2×PERIOD_CYCLES, set lost and go to IDLE.
- Period pairing: the period reported with a pulse is the interval from the previous rise to this pulse's rise. It reads 0 on the first pulse after reset, after lost, or after en re-assertion.
- Conversion:
  - If width_r < MIN_PULSE: pos=0, err_range=1.
  - If width_r > MAX_PULSE: pos=100, err_range=1.
  - Otherwise: pos = ((width_r−MIN_PULSE)×100) / (MAX_PULSE−MIN_PULSE), truncated. ×100 is implemented as (x<<6)+(x<<5)+(x<<2).
  - The divider is always run; clamping is applied to its result.
- lost: set as described in the FSM states; cleared on the next valid.
- en=0: FSM forced to IDLE and counters cleared. An in-flight conversion is aborted and produces no valid. Outputs hold their last values.
- Overrun: if a fall occurs while the divider is busy, that measurement is dropped (no valid). FSM tracking continues normally.
- Reset values: pos=0, width=0, period=0, valid=0, err_range=0, lost=1, FSM=IDLE, divider idle.

## Timing
- pwm_in edge to s2: 2 cycles. The measured width equals the number of cycles s2 is high.
- Fall detected in cycle F: width_r loaded at the end of F.
- Divider start asserted in cycle F+1.
- Divider done strobe in F+25 (DIV_W iterations).
- valid=1 in cycle F+26, with all outputs updated in that same cycle.
- Reset asserted mid-pulse or mid-conversion: reset values apply on the next edge. No valid is produced until a complete new high pulse is seen.
- Simultaneous timeout and edge in the same cycle: the edge wins.

## Structure
- Shared package (pwm_pkg): PERIOD/MIN/MAX defaults, FSM state enum, POS_MAX=100 constant, shared with the generator.
- Sub-module pwm_div: serial restoring divider, DIV_W-bit numerator, DIV_W-bit divisor.
  - Ports: clk, rst, start, num, den, busy, done, quot.
  - Latency: DIV_W cycles from start to done.
  - start while busy is ignored.

## Test plan
All scenarios use scaled parameters PERIOD_CYCLES=1000, MIN_PULSE=25, MAX_PULSE=125, CNT_W=11, DIV_W=24.
- High 75, low 925, repeated 3 pulses -> pos=50, width=75, err_range=0 on every valid. Period=0 on the first valid and 1000 thereafter. Valid exactly 26 cycles after each fall detection; lost cleared after the first valid.
- High 25, then high 125 -> pos=0, then pos=100, err_range=0 both times.
- High 20, then high 140 -> pos=0 with err_range=1, then pos=100 with err_range=1.
- Input held low 2000 cycles after a pulse -> lost=1 at the timeout cycle. The next pulse yields valid with period=0 and lost cleared.
- rst asserted 10 cycles into a high pulse -> all outputs at reset values. No valid for that pulse; the next full pulse is measured correctly.
- en dropped during conversion -> no valid and outputs hold. After en rises, the first full pulse reports period=0.
